// File: rtl/route_1to4_pkg.sv
// route_1to4_pkg: shared constants for the 1-to-4 router.
//   NUM_CH        number of output channels (4)
//   DEFAULT_WIDTH default data width of every channel
//   ch_sel_e      destination select encodings CH0..CH3
package route_1to4_pkg;

  localparam int unsigned NUM_CH        = 4;
  localparam int          DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_sel_e;

endpackage

// File: rtl/route_1to4_slot.sv
// route_slot: single-entry holding register for one router channel.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load      write i_data this edge (caller guarantees slot is empty or draining)
//   i_data      word to store
//   i_ready     consumer takes the held word this cycle
//   o_full      slot holds a word (registered)
//   o_data      held word (registered)
//   o_cnt       delivery counter, present only with ROUTE_CNT_EN defined
module route_slot #(
  parameter int WIDTH = 5
`ifdef ROUTE_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
`ifdef ROUTE_CNT_EN
  , output logic [CNT_W-1:0] o_cnt
`endif
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  // A ready while empty is ignored.
  assign w_drain = r_full & i_ready;

  // Load wins over drain so a same-edge drain+refill keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

`ifdef ROUTE_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/route_1to4.sv
// route_1to4: routes one valid/ready input stream to one of four
// single-entry output channels selected by s.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    upstream offers word I this cycle
//   in_ready    selected channel can take the word (empty, or draining now)
//   s           destination channel select (00..11 -> ch0..ch3)
//   I           offered data word
//   o_valid[k]  channel k holds a word
//   o_ready[k]  channel k consumer takes its word
//   o0..o3      channel held data words
//   dlv_cnt     per-channel delivery counters, channel k at [k*CNT_W +: CNT_W]
// Optional feature: define ROUTE_CNT_EN to add the delivery counters and
// the CNT_W parameter / dlv_cnt port.
module route_1to4
  import route_1to4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef ROUTE_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        s,
  input  logic [WIDTH-1:0]  I,
  output logic [NUM_CH-1:0] o_valid,
  input  logic [NUM_CH-1:0] o_ready,
  output logic [WIDTH-1:0]  o0,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2,
  output logic [WIDTH-1:0]  o3
`ifdef ROUTE_CNT_EN
  , output logic [NUM_CH*CNT_W-1:0] dlv_cnt
`endif
);

  ch_sel_e           w_sel;
  logic [NUM_CH-1:0] w_load;
  logic [WIDTH-1:0]  w_data [NUM_CH];

  assign w_sel = ch_sel_e'(s);

  // in_ready never looks at in_valid.
  assign in_ready = ~o_valid[s] | o_ready[s];

  always_comb begin
    w_load = '0;
    if (in_valid && in_ready) begin
      case (w_sel)
        CH0:     w_load[0] = 1'b1;
        CH1:     w_load[1] = 1'b1;
        CH2:     w_load[2] = 1'b1;
        default: w_load[3] = 1'b1;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    route_slot #(
      .WIDTH (WIDTH)
`ifdef ROUTE_CNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_data  (I),
      .i_ready (o_ready[k]),
      .o_full  (o_valid[k]),
      .o_data  (w_data[k])
`ifdef ROUTE_CNT_EN
      , .o_cnt (dlv_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

  assign o0 = w_data[0];
  assign o1 = w_data[1];
  assign o2 = w_data[2];
  assign o3 = w_data[3];

endmodule

// File: doc/route_1to4.md
ROUTE_1TO4 -- requirements
Module: route_1to4

Interface
REQ-001 Parameter WIDTH, default 5, data width of every channel.
REQ-002 Parameter CNT_W, default 8, width of each per-channel delivery counter (only when ROUTE_CNT_EN is defined).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream offers a word this cycle.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 s  input  2  destination channel select: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
REQ-008 I  input  WIDTH  offered data word.
REQ-009 o_valid  output  4  bit k: channel k holds a word.
REQ-010 o_ready  input  4  bit k: channel k consumer takes the word this cycle.
REQ-011 o0, o1, o2, o3  output  WIDTH each  channel k held data word.
REQ-012 dlv_cnt  output  4*CNT_W  channel k delivery count at bits [k*CNT_W +: CNT_W] (ROUTE_CNT_EN only).

Function
REQ-013 Each channel SHALL have one holding register (data plus full flag); o_valid[k] SHALL equal channel k's full flag, registered, no combinational path from inputs.
REQ-014 Accept condition: in_valid=1 and in_ready=1; the word SHALL be written to channel s on that edge only; other channels unaffected.
REQ-015 in_ready SHALL be 1 when channel s is empty, or full with o_ready[s]=1 in the same cycle (pass-through refill); otherwise 0.
REQ-016 in_ready SHALL depend combinationally only on s, o_valid, o_ready; never on in_valid.
REQ-017 Drain: o_valid[k]=1 and o_ready[k]=1 SHALL clear channel k on the edge unless refilled that edge per REQ-015, in which case it stays full with the new word.
REQ-018 Latency SHALL be exactly 1 cycle: word accepted at edge N is visible on o_k with o_valid[k]=1 after edge N.
REQ-019 While o_valid[k]=1 and o_ready[k]=0, o_k and o_valid[k] SHALL hold stable.
REQ-020 All four channels SHALL drain independently and simultaneously in one cycle.
REQ-021 o_ready[k] while o_valid[k]=0 SHALL have no effect.
REQ-022 Per channel state: EMPTY -> FULL on accept; FULL -> EMPTY on drain without refill; FULL -> FULL on drain with refill or stall.
REQ-023 Word order per channel SHALL be preserved; no word dropped or duplicated.

Reset
REQ-024 rst_n=0 SHALL immediately clear all full flags: o_valid=4'b0000, o0..o3=0, dlv_cnt=0, independent of clk.
REQ-025 Reset mid-operation SHALL discard held words; first accept after rst_n rises SHALL behave as from empty.
REQ-026 in_ready during reset SHALL be 1 (all channels empty); words offered while rst_n=0 SHALL NOT be stored.

Configuration
REQ-027 Macro ROUTE_CNT_EN: when defined, each channel SHALL keep a CNT_W-bit counter incremented by 1 on each drain (o_valid[k]&o_ready[k]), wrapping from all-ones to 0, exposed on dlv_cnt.
REQ-028 Without ROUTE_CNT_EN, counters and the dlv_cnt port SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold channel-count constant (4), select encodings CH0..CH3, and default WIDTH.
REQ-030 One sub-module route_slot SHALL implement a single channel holding register (load, drain, full flag, optional counter), instantiated four times; select decode and in_ready mux in the top.

Verification
REQ-031 Reset then s=01, I=5'h15, in_valid=1 one cycle, o_ready=0 -> next cycle o_valid=4'b0010, o1=5'h15, others unchanged.
REQ-032 Ch2 full, o_ready[2]=0, offer s=10 I=5'h03 -> in_ready=0, o2 unchanged; same offer with o_ready[2]=1 -> in_ready=1, o2=5'h03 next cycle, o_valid[2] stays 1.
REQ-033 Fill all four channels with 5'h01..5'h04, then o_ready=4'b1111 one cycle -> o_valid=4'b0000 next cycle, each channel delivered its own value.
REQ-034 Ch0 stalled full, offer s=11 I=5'h1F -> in_ready=1, ch3 loads 5'h1F; ch0 untouched.
REQ-035 Assert rst_n=0 between edges with channels full -> o_valid=0 immediately; after release, single accept to ch1 gives o_valid=4'b0010.
REQ-036 ROUTE_CNT_EN, CNT_W=8: 257 drains on ch0 -> dlv_cnt[7:0]=8'h01, other counters 0.
